// File: rtl/sample_capture_ctrl_pkg.sv
// Shared types and constants for the RX sample-capture front end.
package sample_capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    CAPTURE,
    PARITY,
    STOP,
    DONE
  } state_e;

  // The downstream decoder is built for exactly ten oversamples per bit.
  localparam int SAMPLES_PER_BIT = 10;
  localparam int VOTE_THRESHOLD  = 5;
  localparam int CODE_W          = 8;
  localparam int SAMPLE_W        = SAMPLES_PER_BIT * CODE_W;

  // Majority decision for one bit window; a 5/5 tie resolves to 1.
  function automatic logic vote_is_one(input logic [3:0] ones_cnt);
    return ones_cnt >= 4'(VOTE_THRESHOLD);
  endfunction

endpackage

// File: rtl/sample_capture_ctrl_if.sv
// Bundle between the capture sequencer (master) and the line/decoder side
// (slave). parity_err exists only when SAMPLE_CAPTURE_CTRL_PARITY_EN is defined.
interface sample_capture_ctrl_if;
  import sample_capture_pkg::*;

  logic                enable;
  logic                rx_in;
  logic                sample_flag;
  logic [SAMPLE_W-1:0] sample;
  logic [CODE_W-1:0]   code_in;
  logic [CODE_W-1:0]   code_out;
  logic                code_valid;
  logic                frame_err;
  logic                busy;
`ifdef SAMPLE_CAPTURE_CTRL_PARITY_EN
  logic                parity_err;

  modport master (
    input  enable, rx_in, code_in,
    output sample_flag, sample, code_out, code_valid, frame_err, busy, parity_err
  );

  modport slave (
    output enable, rx_in, code_in,
    input  sample_flag, sample, code_out, code_valid, frame_err, busy, parity_err
  );
`else
  modport master (
    input  enable, rx_in, code_in,
    output sample_flag, sample, code_out, code_valid, frame_err, busy
  );

  modport slave (
    output enable, rx_in, code_in,
    input  sample_flag, sample, code_out, code_valid, frame_err, busy
  );
`endif

endinterface

// File: rtl/sample_capture_ctrl_window_vote.sv
// Ones-counter over a ten-strobe bit window. count_o already includes the
// bit presented with the current strobe, so it is final when done_o is high
// and holds that value until the next clear.
module window_vote (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       stb_i,
  input  logic       bit_i,
  output logic [3:0] count_o,
  output logic       done_o
);
  import sample_capture_pkg::*;

  logic [3:0] cnt_q;
  logic [3:0] n_q;

  // Accumulate ones and count strobes within the current window.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
      n_q   <= '0;
    end else if (stb_i) begin
      cnt_q <= cnt_q + {3'b000, bit_i};
      n_q   <= (n_q == 4'(SAMPLES_PER_BIT - 1)) ? 4'd0 : n_q + 4'd1;
    end
  end

  assign count_o = cnt_q + {3'b000, stb_i & bit_i};
  assign done_o  = stb_i && (n_q == 4'(SAMPLES_PER_BIT - 1));

endmodule

// File: rtl/sample_capture_ctrl.sv
// Start-bit detection, oversampled capture and framing for the RX decoder.
// Optional parity bit window enabled by SAMPLE_CAPTURE_CTRL_PARITY_EN.
module sample_capture_ctrl #(
  parameter int CLKS_PER_SAMPLE = 16,
  parameter int SAMPLES_PER_BIT = 10,
  parameter int BITS_PER_CODE   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sample_capture_ctrl_if.master bus
);
  import sample_capture_pkg::*;

  localparam int CAP_W = SAMPLES_PER_BIT * BITS_PER_CODE;
  localparam int IDX_W = $clog2(CAP_W);
  localparam int DIV_W = $clog2(CLKS_PER_SAMPLE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_SAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CAP_W - 1);

  state_e                   state_q, state_d;
  logic [DIV_W-1:0]         div_q;
  logic                     strobe;
  logic [IDX_W-1:0]         cap_idx_q, cap_idx_d;
  logic [CAP_W-1:0]         sample_q, sample_d;
  logic                     flag_q, flag_d;
  logic [BITS_PER_CODE-1:0] code_out_q, code_out_d;
  logic                     valid_q, valid_d;
  logic                     err_q, err_d;
  logic                     stop_ok;
`ifdef SAMPLE_CAPTURE_CTRL_PARITY_EN
  logic                     parity_bit_q, parity_bit_d;
  logic                     perr_q, perr_d;
  logic                     par_ok;
`endif

  logic                     vote_clr;
  logic                     vote_stb;
  logic [3:0]               vote_cnt;
  logic                     vote_done;

  // Oversample divider: held at zero in IDLE so the first strobe lands
  // CLKS_PER_SAMPLE cycles after the start edge is seen.
  always_ff @(posedge clk) begin
    if (rst || state_q == IDLE) begin
      div_q <= '0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign strobe   = (state_q != IDLE) && (div_q == DIV_LAST);
  assign vote_stb = strobe &&
                    (state_q == START || state_q == PARITY || state_q == STOP);

  window_vote u_vote (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (vote_clr),
    .stb_i   (vote_stb),
    .bit_i   (bus.rx_in),
    .count_o (vote_cnt),
    .done_o  (vote_done)
  );

  // Next-state, capture writes and end-of-frame result pulses.
  always_comb begin
    state_d    = state_q;
    cap_idx_d  = cap_idx_q;
    sample_d   = sample_q;
    flag_d     = flag_q;
    code_out_d = code_out_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    vote_clr   = 1'b0;
    stop_ok    = vote_is_one(vote_cnt);
`ifdef SAMPLE_CAPTURE_CTRL_PARITY_EN
    parity_bit_d = parity_bit_q;
    perr_d       = 1'b0;
    par_ok       = ((^bus.code_in) == parity_bit_q);
`endif

    case (state_q)
      IDLE: begin
        if (bus.enable && !bus.rx_in) begin
          state_d  = START;
          vote_clr = 1'b1;
        end
      end
      START: begin
        if (vote_done) begin
          if (vote_is_one(vote_cnt)) begin
            state_d = IDLE;
          end else begin
            state_d   = CAPTURE;
            flag_d    = 1'b1;
            cap_idx_d = '0;
          end
        end
      end
      CAPTURE: begin
        if (strobe) begin
          sample_d[cap_idx_q] = bus.rx_in;
          if (cap_idx_q == IDX_LAST) begin
            // Flag falls in the same update as the last write, so the bus
            // is already final on the cycle the decoder sees the fall.
            flag_d   = 1'b0;
            vote_clr = 1'b1;
`ifdef SAMPLE_CAPTURE_CTRL_PARITY_EN
            state_d  = PARITY;
`else
            state_d  = STOP;
`endif
          end else begin
            cap_idx_d = cap_idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
`ifdef SAMPLE_CAPTURE_CTRL_PARITY_EN
        if (vote_done) begin
          parity_bit_d = vote_is_one(vote_cnt);
          state_d      = STOP;
          vote_clr     = 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (vote_done) begin
          state_d    = DONE;
          code_out_d = bus.code_in;
          err_d      = !stop_ok;
`ifdef SAMPLE_CAPTURE_CTRL_PARITY_EN
          valid_d    = stop_ok && par_ok;
          perr_d     = !par_ok;
`else
          valid_d    = stop_ok;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cap_idx_q  <= '0;
      sample_q   <= '0;
      flag_q     <= 1'b0;
      code_out_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
`ifdef SAMPLE_CAPTURE_CTRL_PARITY_EN
      parity_bit_q <= 1'b0;
      perr_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cap_idx_q  <= cap_idx_d;
      sample_q   <= sample_d;
      flag_q     <= flag_d;
      code_out_q <= code_out_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
`ifdef SAMPLE_CAPTURE_CTRL_PARITY_EN
      parity_bit_q <= parity_bit_d;
      perr_q       <= perr_d;
`endif
    end
  end

  assign bus.sample_flag = flag_q;
  assign bus.sample      = sample_q;
  assign bus.code_out    = code_out_q;
  assign bus.code_valid  = valid_q;
  assign bus.frame_err   = err_q;
  assign bus.busy        = (state_q != IDLE);
`ifdef SAMPLE_CAPTURE_CTRL_PARITY_EN
  assign bus.parity_err  = perr_q;
`endif

endmodule
